// File: rtl/imem_line_loader_if.sv
// Word stream into the line loader and the SRAM write port it drives.
// The loader takes the slave side; the word source and the memory take the master side.
interface imem_line_loader_if #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 6,
    parameter int ADDR_W         = 8
);
    localparam int LINE_W = WORD_W * WORDS_PER_LINE;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              WE;
    logic [ADDR_W-1:0] WriteAddress;
    logic [LINE_W-1:0] WriteBus;

    modport slave (
        input  in_valid, in_data,
        output in_ready, WE, WriteAddress, WriteBus
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, WE, WriteAddress, WriteBus
    );
endinterface

// File: rtl/imem_line_loader.sv
// Packs WORDS_PER_LINE instruction words into one SRAM line and writes the lines
// to consecutive addresses starting at base_addr. The address counter wraps modulo the depth.
module imem_line_loader #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 6,
    parameter int ADDR_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_lines,
    imem_line_loader_if.slave bus,
    output logic              busy,
    output logic              done
);
    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int IDX_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, FINISH} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [LINE_W-1:0] wbus_q, wbus_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        idx_d    = idx_q;
        line_d   = line_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wbus_d   = wbus_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = num_lines;
                    idx_d    = '0;
                    state_d  = (num_lines == '0) ? FINISH : FILL;
                end
            end
            FILL: begin
                if (bus.in_valid) begin
                    line_d[idx_q*WORD_W +: WORD_W] = bus.in_data;
                    if (idx_q == LAST_IDX) begin
                        // Output registers load with the finished line so WE, address and data align.
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wbus_d  = line_d;
                        state_d = WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                addr_d   = addr_q + 1'b1;
                remain_d = remain_q - 1'b1;
                idx_d    = '0;
                state_d  = (remain_q == (ADDR_W+1)'(1)) ? FINISH : FILL;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            idx_q    <= '0;
            line_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wbus_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            idx_q    <= idx_d;
            line_q   <= line_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wbus_q   <= wbus_d;
        end
    end

    assign bus.in_ready     = (state_q == FILL);
    assign bus.WE           = we_q;
    assign bus.WriteAddress = waddr_q;
    assign bus.WriteBus     = wbus_q;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == FINISH);
endmodule
